// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC capture path (write side and read side).
package adc_pkg;

    localparam int         DW_DEFAULT       = 16;
    localparam logic [7:0] HDR_MARK_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_RST_FIFO  = 3'd0,
        ST_RST_WAIT  = 3'd1,
        ST_IDLE      = 3'd2,
        ST_WAIT_TRIG = 3'd3,
        ST_HEADER    = 3'd4,
        ST_CAPTURE   = 3'd5,
        ST_DRAIN     = 3'd6
    } cap_state_e;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector. The history flop clears to 0 on reset, so a level that is
// already high when reset releases is reported as an edge.
module edge_det (
    input  logic clk,
    input  logic rstn,
    input  logic i_d,
    output logic o_rise
);

    logic r_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_d <= 1'b0;
        else       r_d <= i_d;
    end

    assign o_rise = i_d & ~r_d;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Write-side controller for the ADC sample FIFO: FIFO reset sequencing, trigger,
// header word, decimated sample capture until full, then hold until drained.
//
// state      | meaning
// RST_FIFO   | fifo_rst high for RST_CYCLES cycles
// RST_WAIT   | fifo_rst low, writes blocked for RST_WAIT cycles
// IDLE       | wait for arm with an empty FIFO
// WAIT_TRIG  | wait for a trig rising edge (arm drop returns to IDLE)
// HEADER     | one cycle, write {HDR_MARK, frame_cnt}
// CAPTURE    | write every DECIM-th valid sample until full
// DRAIN      | wait for empty, count the frame
module adc_capture_ctrl
    import adc_pkg::*;
#(
    parameter int         DW         = DW_DEFAULT,
    parameter int         DECIM      = 1,
    parameter int         RST_CYCLES = 8,
    parameter int         RST_WAIT   = 32,
    parameter logic [7:0] HDR_MARK   = HDR_MARK_DEFAULT
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clear,
    input  logic          arm,
    input  logic          trig,
    input  logic          adc_valid,
    input  logic [DW-1:0] adc_data,
    input  logic          full,
    input  logic          empty,
    output logic          fifo_rst,
    output logic          wr_en,
    output logic [DW-1:0] wr_data,
    output logic [DW-9:0] frame_cnt,
    output logic          busy,
    output logic [2:0]    state
);

    localparam int TMAX = (RST_CYCLES > RST_WAIT) ? RST_CYCLES : RST_WAIT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int DCW  = 8;

    localparam logic [TW-1:0]  TMR_RST  = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0]  TMR_WAIT = TW'(RST_WAIT - 1);
    localparam logic [DCW-1:0] DCNT_MAX = DCW'(DECIM - 1);

    cap_state_e     r_state;
    logic [TW-1:0]  r_tmr;
    logic [DCW-1:0] r_dcnt;
    logic [DW-1:0]  r_sample_q;
    logic           r_vld_q;
    logic [DW-9:0]  r_frame_cnt;

    logic w_trig_rise;
    logic w_tmr_tc;
    logic w_in_capt;

    edge_det u_trig_edge (
        .clk    (clk),
        .rstn   (rstn),
        .i_d    (trig),
        .o_rise (w_trig_rise)
    );

    assign w_tmr_tc  = (r_tmr == '0);
    // HEADER counts as a capture cycle so the sample offered alongside the header is kept.
    assign w_in_capt = (r_state == ST_HEADER) || (r_state == ST_CAPTURE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_RST_FIFO;
            r_tmr       <= TMR_RST;
            r_dcnt      <= '0;
            r_sample_q  <= '0;
            r_vld_q     <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_sample_q <= adc_data;
            r_vld_q    <= w_in_capt && adc_valid && (r_dcnt == '0);
            if (w_in_capt && adc_valid)
                r_dcnt <= (r_dcnt == DCNT_MAX) ? '0 : r_dcnt + 1'b1;

            if (clear) begin
                r_state <= ST_RST_FIFO;
                r_tmr   <= TMR_RST;
            end else begin
                case (r_state)
                    ST_RST_FIFO: begin
                        if (w_tmr_tc) begin
                            r_state <= ST_RST_WAIT;
                            r_tmr   <= TMR_WAIT;
                        end else begin
                            r_tmr <= r_tmr - 1'b1;
                        end
                    end
                    ST_RST_WAIT: begin
                        if (w_tmr_tc) r_state <= ST_IDLE;
                        else          r_tmr   <= r_tmr - 1'b1;
                    end
                    ST_IDLE: begin
                        if (arm && empty) r_state <= ST_WAIT_TRIG;
                    end
                    ST_WAIT_TRIG: begin
                        if (!arm) begin
                            r_state <= ST_IDLE;
                        end else if (w_trig_rise) begin
                            r_state <= ST_HEADER;
                            r_dcnt  <= '0;
                        end
                    end
                    ST_HEADER: begin
                        r_state <= full ? ST_DRAIN : ST_CAPTURE;
                    end
                    ST_CAPTURE: begin
                        if (full) r_state <= ST_DRAIN;
                    end
                    ST_DRAIN: begin
                        if (empty) begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_RST_FIFO;
                        r_tmr   <= TMR_RST;
                    end
                endcase
            end
        end
    end

    // Writes are gated by full combinationally so nothing is ever written into a full FIFO.
    assign wr_en    = ~full & ((r_state == ST_HEADER) |
                               ((r_state == ST_CAPTURE) & r_vld_q));
    assign wr_data  = (r_state == ST_HEADER) ? {HDR_MARK, r_frame_cnt} : r_sample_q;
    assign fifo_rst = (r_state == ST_RST_FIFO);
    assign busy     = (r_state != ST_IDLE);
    assign state    = r_state;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl: one instance with DECIM=1, one with DECIM=4.
module tb_adc_capture_ctrl;

    localparam int DW = 16;

    logic          clk       = 1'b0;
    logic          rstn      = 1'b0;
    logic          clear     = 1'b0;
    logic          arm       = 1'b0;
    logic          trig      = 1'b0;
    logic          adc_valid = 1'b0;
    logic [DW-1:0] adc_data  = '0;
    logic          full      = 1'b0;
    logic          full4     = 1'b0;
    logic          empty     = 1'b1;

    logic          fifo_rst, wr_en, busy;
    logic [DW-1:0] wr_data;
    logic [DW-9:0] frame_cnt;
    logic [2:0]    state;

    logic          fifo_rst4, wr_en4, busy4;
    logic [DW-1:0] wr_data4;
    logic [DW-9:0] frame_cnt4;
    logic [2:0]    state4;

    always #5 clk = ~clk;

    adc_capture_ctrl #(.DW(DW), .DECIM(1)) u_dut (
        .clk(clk), .rstn(rstn), .clear(clear), .arm(arm), .trig(trig),
        .adc_valid(adc_valid), .adc_data(adc_data), .full(full), .empty(empty),
        .fifo_rst(fifo_rst), .wr_en(wr_en), .wr_data(wr_data),
        .frame_cnt(frame_cnt), .busy(busy), .state(state)
    );

    adc_capture_ctrl #(.DW(DW), .DECIM(4)) u_dut4 (
        .clk(clk), .rstn(rstn), .clear(clear), .arm(arm), .trig(trig),
        .adc_valid(adc_valid), .adc_data(adc_data), .full(full4), .empty(empty),
        .fifo_rst(fifo_rst4), .wr_en(wr_en4), .wr_data(wr_data4),
        .frame_cnt(frame_cnt4), .busy(busy4), .state(state4)
    );

    logic [DW-1:0] q_wr[$];
    logic [DW-1:0] q_wr4[$];
    int n_viol = 0;

    always @(negedge clk) begin
        if (wr_en)  q_wr.push_back(wr_data);
        if (wr_en4) q_wr4.push_back(wr_data4);
        if (wr_en && full)   n_viol++;
        if (wr_en4 && full4) n_viol++;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [15:0] exp4 [5];
        exp4[0] = 16'hA500; exp4[1] = 16'd0; exp4[2] = 16'd4; exp4[3] = 16'd8; exp4[4] = 16'd12;

        #12;
        chk("rst_state",     32'(state), 0);
        chk("rst_fifo_rst",  32'(fifo_rst), 1);
        chk("rst_wr_en",     32'(wr_en), 0);
        chk("rst_wr_data",   32'(wr_data), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_busy",      32'(busy), 1);
        chk("rst_fifo_rst4", 32'(fifo_rst4), 1);

        tick;
        rstn = 1'b1;
        n = 0;
        while (fifo_rst && n < 100) begin tick; n++; end
        chk("rst_fifo_cycles", 32'(n), 8);
        chk("state_rst_wait", 32'(state), 1);
        n = 0;
        while (state != 3'd2 && n < 100) begin tick; n++; end
        chk("rst_wait_cycles", 32'(n), 32);
        chk("no_wr_during_init", 32'(q_wr.size()), 0);
        chk("busy_idle", 32'(busy), 0);

        // frame 0: DECIM=1 fills after 10 writes, DECIM=4 after 5
        arm = 1'b1;
        tick;
        chk("state_wait_trig", 32'(state), 3);
        trig = 1'b1;
        tick;
        chk("state_header", 32'(state), 4);
        trig = 1'b0; adc_valid = 1'b1; adc_data = '0; empty = 1'b0;
        n = 0;
        while (!(full && full4) && n < 60) begin
            tick; n++;
            adc_data = adc_data + 1'b1;
            if (q_wr.size() >= 10) full = 1'b1;
            if (q_wr4.size() >= 5) full4 = 1'b1;
        end
        adc_valid = 1'b0;
        tick;
        chk("state_drain",  32'(state), 6);
        chk("state4_drain", 32'(state4), 6);
        chk("f0_wr_count",  32'(q_wr.size()), 10);
        if (q_wr.size() == 10) begin
            chk("f0_header", 32'(q_wr[0]), 32'h0000A500);
            for (int i = 1; i < 10; i++) chk("f0_sample", 32'(q_wr[i]), 32'(i - 1));
        end
        chk("d4_wr_count", 32'(q_wr4.size()), 5);
        if (q_wr4.size() == 5)
            for (int i = 0; i < 5; i++) chk("d4_sample", 32'(q_wr4[i]), 32'(exp4[i]));

        full = 1'b0; full4 = 1'b0;
        repeat (50) tick;
        chk("drain_hold",      32'(state), 6);
        chk("drain_frame_cnt", 32'(frame_cnt), 0);
        empty = 1'b1;
        tick;
        chk("drain_to_idle", 32'(state), 2);
        chk("frame_cnt_inc", 32'(frame_cnt), 1);
        chk("frame_cnt4_inc", 32'(frame_cnt4), 1);
        empty = 1'b0;
        tick;
        chk("idle_not_empty", 32'(state), 2);
        empty = 1'b1;
        tick;
        chk("idle_to_wait_trig", 32'(state), 3);

        // trig already high when arming must not start a frame
        arm = 1'b0;
        tick;
        chk("disarm_to_idle", 32'(state), 2);
        trig = 1'b1;
        repeat (3) tick;
        arm = 1'b1;
        tick;
        chk("rearm_wait_trig", 32'(state), 3);
        repeat (5) tick;
        chk("trig_held_no_start", 32'(state), 3);
        trig = 1'b0;
        tick;
        trig = 1'b1;
        tick;
        chk("trig_reedge_header", 32'(state), 4);
        q_wr.delete();
        trig = 1'b0; adc_valid = 1'b1; adc_data = '0; empty = 1'b0;
        repeat (4) begin tick; adc_data = adc_data + 1'b1; end
        chk("f1_wr_count", 32'(q_wr.size()), 4);
        if (q_wr.size() == 4) begin
            chk("f1_header",  32'(q_wr[0]), 32'h0000A501);
            chk("f1_sample0", 32'(q_wr[1]), 0);
        end
        chk("pre_clear_wr_en", 32'(wr_en), 1);

        clear = 1'b1;
        tick;
        clear = 1'b0;
        chk("clear_wr_en",     32'(wr_en), 0);
        chk("clear_state",     32'(state), 0);
        chk("clear_fifo_rst",  32'(fifo_rst), 1);
        chk("clear_frame_cnt", 32'(frame_cnt), 1);
        n = 0;
        while (fifo_rst && n < 100) begin tick; n++; end
        chk("clear_fifo_cycles", 32'(n), 8);
        chk("clear_frame_cnt_after", 32'(frame_cnt), 1);

        // async reset in the middle of a frame
        adc_valid = 1'b0; empty = 1'b1; arm = 1'b1; trig = 1'b0;
        n = 0;
        while (state != 3'd3 && n < 100) begin tick; n++; end
        chk("rearm_after_clear", 32'(state), 3);
        trig = 1'b1;
        tick;
        trig = 1'b0; adc_valid = 1'b1; adc_data = 16'h0100; empty = 1'b0;
        repeat (3) tick;
        chk("pre_rst_capture", 32'(state), 5);
        chk("pre_rst_wr_en",   32'(wr_en), 1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_state",     32'(state), 0);
        chk("arst_fifo_rst",  32'(fifo_rst), 1);
        chk("arst_wr_en",     32'(wr_en), 0);
        chk("arst_wr_data",   32'(wr_data), 0);
        chk("arst_frame_cnt", 32'(frame_cnt), 0);
        chk("arst_busy",      32'(busy), 1);
        chk("arst_busy4",     32'(busy4), 1);

        chk("no_wr_while_full", 32'(n_viol), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
